// File: rtl/coherence_bus_ctrl.sv
// Two-master snooping bus controller: round-robin arbitration of dcache write-backs,
// snooped block fills and invalidates onto a single-port RAM, with cache-to-cache forwarding.
module coherence_bus_ctrl #(
  parameter int WORD_W    = 32,
  parameter int BLK_WORDS = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [1:0]             dREN,
  input  logic [1:0]             dWEN,
  input  logic [1:0]             ccwrite,
  input  logic [1:0]             cctrans,
  input  logic [1:0][WORD_W-1:0] daddr,
  input  logic [1:0][WORD_W-1:0] dstore,
  output logic [1:0]             dwait,
  output logic [1:0][WORD_W-1:0] dload,
  output logic [1:0]             ccwait,
  output logic [1:0]             ccinv,
  output logic [1:0][WORD_W-1:0] ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic                   ramwait
);

  localparam int CNT_W = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLK_WORDS - 1);

  typedef enum logic [2:0] {IDLE, WB, SNP, XFER, INV} state_t;

  state_t            state;
  logic              r;        // granted cache
  logic              o;        // snoopee
  logic              rr_ptr;   // favoured cache on a contested grant
  logic [CNT_W-1:0]  cnt;
  logic              snp_inv;
  logic [WORD_W-1:0] snp_addr;
  logic [1:0]        req;
  logic              gnt_sel;
  logic              keep;

  assign o   = ~r;
  assign req = dREN | dWEN | ccwrite;

  always_comb begin
    gnt_sel = req[1];
    if (&req) gnt_sel = rr_ptr;
  end

  // The granted kind's own request must stay high; otherwise the transfer is dropped.
  always_comb begin
    keep = 1'b1;
    case (state)
      WB:        keep = dWEN[r];
      SNP, XFER: keep = dREN[r];
      INV:       keep = ccwrite[r];
      default:   keep = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= IDLE;
      r        <= 1'b0;
      rr_ptr   <= 1'b0;
      cnt      <= '0;
      snp_inv  <= 1'b0;
      snp_addr <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          r   <= gnt_sel;
          cnt <= '0;
          if (&req) rr_ptr <= ~gnt_sel;
          if (dWEN[gnt_sel])      state <= WB;
          else if (dREN[gnt_sel]) state <= SNP;
          else                    state <= INV;
        end
        WB: begin
          if (!keep) state <= IDLE;
          else if (!ramwait) begin
            if (cnt == LAST) state <= IDLE;
            else             cnt   <= cnt + 1'b1;
          end
        end
        SNP: begin
          if (!keep) state <= IDLE;
          else begin
            snp_inv  <= ccwrite[r];
            snp_addr <= daddr[r];
            state    <= XFER;
          end
        end
        XFER: begin
          if (!keep) state <= IDLE;
          else if (!ramwait) begin
            if (cnt == LAST) state <= IDLE;
            else begin
              cnt   <= cnt + 1'b1;
              state <= SNP;
            end
          end
        end
        INV:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are combinational so dwait/dload track ramwait/ramload in the same cycle.
  always_comb begin
    dwait       = 2'b11;
    dload       = '0;
    ccwait      = 2'b00;
    ccinv       = 2'b00;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    if (nRST && keep) begin
      case (state)
        WB: begin
          ramWEN   = 1'b1;
          ramaddr  = daddr[r];
          ramstore = dstore[r];
          dwait[r] = ramwait;
        end
        SNP: begin
          ccwait[o]      = 1'b1;
          ccinv[o]       = ccwrite[r];
          ccsnoopaddr[o] = daddr[r];
        end
        XFER: begin
          ccwait[o]      = 1'b1;
          ccinv[o]       = snp_inv;
          ccsnoopaddr[o] = snp_addr;
          ramaddr        = daddr[r];
          dwait[r]       = ramwait;
          if (cctrans[o]) begin
            dload[r] = dstore[o];
            ramWEN   = 1'b1;
            ramstore = dstore[o];
          end else begin
            dload[r] = ramload;
            ramREN   = 1'b1;
          end
        end
        INV: begin
          ccwait[o]      = 1'b1;
          ccinv[o]       = 1'b1;
          ccinv[r]       = 1'b1;
          ccsnoopaddr[o] = daddr[r];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Scoreboard bench for coherence_bus_ctrl: directed cache scenarios against a latency-programmable RAM.
module tb_coherence_bus_ctrl;
  localparam int W = 32;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       dREN, dWEN, ccwrite, cctrans;
  logic [1:0][W-1:0] daddr, dstore;
  logic [1:0]       dwait, ccwait, ccinv;
  logic [1:0][W-1:0] dload, ccsnoopaddr;
  logic             ramREN, ramWEN, ramwait;
  logic [W-1:0]     ramaddr, ramstore, ramload;

  coherence_bus_ctrl #(.WORD_W(W), .BLK_WORDS(2)) dut (
    .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .ccwrite(ccwrite), .cctrans(cctrans),
    .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramwait(ramwait));

  always #5 CLK = ~CLK;

  // RAM: a strobed access completes after lat cycles; read data = address ^ 0xCAFE0000.
  int lat = 2;
  int ram_cnt = 0;
  assign ramwait = (ram_cnt < lat - 1);
  assign ramload = ramaddr ^ 32'hCAFE_0000;
  always @(posedge CLK) ram_cnt <= (ramREN | ramWEN) ? (ramwait ? ram_cnt + 1 : 0) : 0;

  typedef struct packed {
    logic [1:0]        dwait;
    logic [1:0][W-1:0] dload;
    logic              ren;
    logic              wen;
    logic [W-1:0]      raddr;
    logic [W-1:0]      rstore;
    logic [1:0]        ccwait;
    logic [1:0]        ccinv;
    logic [1:0][W-1:0] snp;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  inv_hold = 0;

  function automatic ev_t ev_idle();
    ev_t e = '0;
    e.dwait = 2'b11;
    return e;
  endfunction

  function automatic ev_t ev_rd(input int c, input logic [W-1:0] a, input logic [W-1:0] d,
                                input bit fwd, input bit inv);
    ev_t e = ev_idle();
    e.dwait[c]    = 1'b0;
    e.dload[c]    = d;
    e.raddr       = a;
    e.ccwait[1-c] = 1'b1;
    e.ccinv[1-c]  = inv;
    e.snp[1-c]    = a;
    if (fwd) begin e.wen = 1'b1; e.rstore = d; end
    else e.ren = 1'b1;
    return e;
  endfunction

  function automatic ev_t ev_wb(input int c, input logic [W-1:0] a, input logic [W-1:0] d);
    ev_t e = ev_idle();
    e.dwait[c] = 1'b0;
    e.wen      = 1'b1;
    e.raddr    = a;
    e.rstore   = d;
    return e;
  endfunction

  function automatic ev_t ev_inv(input int c, input logic [W-1:0] a);
    ev_t e = ev_idle();
    e.ccwait[1-c] = 1'b1;
    e.ccinv       = 2'b11;
    e.snp[1-c]    = a;
    return e;
  endfunction

  function automatic ev_t sample();
    ev_t g;
    g.dwait = dwait; g.dload = dload; g.ren = ramREN; g.wen = ramWEN;
    g.raddr = ramaddr; g.rstore = ramstore; g.ccwait = ccwait; g.ccinv = ccinv;
    g.snp = ccsnoopaddr;
    return g;
  endfunction

  task automatic check(input string name, input ev_t got, input ev_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Pops an expectation on every word completion or invalidate ack; checks bus rules every cycle.
  task automatic monitor();
    ev_t got;
    forever begin
      @(negedge CLK);
      if (nRST === 1'b1) begin
        got = sample();
        n_cmp++;
        if ((ramREN && ramWEN) || |(ccwait & ~dwait)) begin
          n_bad++;
          $display("FAIL invariant: ren=%b wen=%b ccwait=%b dwait=%b", ramREN, ramWEN, ccwait, dwait);
        end
        if (inv_hold && ccwait[1]) begin
          n_cmp++;
          if (ccinv[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL inv_hold: ccinv[1]=%b want 1", ccinv[1]);
          end
        end
        if (dwait != 2'b11 || |(ccinv & ~ccwait)) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected event: got %h", got);
          end else check("event", got, exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++; n_bad++;
    $display("FAIL timeout %s: event not seen, want it within bound", name);
  endtask

  task automatic wait_word(input int c, input string name);
    bit ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (dwait[c] == 1'b0) begin ok = 1; break; end
    end
    if (!ok) timeout(name);
    @(posedge CLK); #1;
  endtask

  task automatic rd(input int c, input logic [W-1:0] a, input bit ex);
    dREN[c] = 1'b1; ccwrite[c] = ex; daddr[c] = a;
    wait_word(c, "rd word0");
    daddr[c] = a + 4;
    wait_word(c, "rd word1");
    dREN[c] = 1'b0; ccwrite[c] = 1'b0;
  endtask

  task automatic wb(input int c, input logic [W-1:0] a, input logic [W-1:0] d);
    dWEN[c] = 1'b1; daddr[c] = a; dstore[c] = d;
    wait_word(c, "wb word0");
    daddr[c] = a + 4; dstore[c] = d + 4;
    wait_word(c, "wb word1");
    dWEN[c] = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge CLK);
    if (exp_q.size() != 0) begin
      timeout(name);
      exp_q.delete();
    end
  endtask

  task automatic wait_strobe(input string name);
    bit ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (ramREN || ramWEN) begin ok = 1; break; end
    end
    if (!ok) timeout(name);
    @(posedge CLK); #1;
  endtask

  initial begin
    nRST = 1'b0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0; daddr = '0; dstore = '0;
    fork monitor(); join_none

    // reset state, also with a request pending
    repeat (2) @(negedge CLK);
    check("reset_idle", sample(), ev_idle());
    dREN[0] = 1'b1; daddr[0] = 32'h10;
    @(negedge CLK);
    check("reset_req", sample(), ev_idle());
    dREN[0] = 1'b0;
    @(posedge CLK); #1 nRST = 1'b1;

    // fill from RAM, no dirty copy elsewhere
    exp_q.push_back(ev_rd(0, 32'h100, 32'hCAFE_0100, 0, 0));
    exp_q.push_back(ev_rd(0, 32'h104, 32'hCAFE_0104, 0, 0));
    rd(0, 32'h100, 0);
    drain("fill_ram");

    // fill forwarded from C1's dirty line and written through
    cctrans[1] = 1'b1; dstore[1] = 32'hDEAD_BEEF;
    exp_q.push_back(ev_rd(0, 32'h200, 32'hDEAD_BEEF, 1, 0));
    exp_q.push_back(ev_rd(0, 32'h204, 32'hDEAD_BEEF, 1, 0));
    rd(0, 32'h200, 0);
    drain("fill_fwd");
    cctrans[1] = 1'b0;

    // write-hit invalidate from C1
    exp_q.push_back(ev_inv(1, 32'h300));
    ccwrite[1] = 1'b1; daddr[1] = 32'h300;
    begin
      bit ok = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge CLK);
        if (ccinv[1]) begin ok = 1; break; end
      end
      if (!ok) timeout("inv");
    end
    @(posedge CLK); #1 ccwrite[1] = 1'b0;
    drain("inv");

    // contested write-backs straight out of reset: C0 first, then C1
    nRST = 1'b0;
    @(posedge CLK); #1;
    exp_q.push_back(ev_wb(0, 32'h500, 32'h1111_0000));
    exp_q.push_back(ev_wb(0, 32'h504, 32'h1111_0004));
    exp_q.push_back(ev_wb(1, 32'h600, 32'h2222_0000));
    exp_q.push_back(ev_wb(1, 32'h604, 32'h2222_0004));
    dWEN = 2'b11;
    nRST = 1'b1;
    fork
      wb(0, 32'h500, 32'h1111_0000);
      wb(1, 32'h600, 32'h2222_0000);
    join
    drain("rr_first");

    // contested again: round-robin now favours C1
    exp_q.push_back(ev_wb(1, 32'h600, 32'h2222_0000));
    exp_q.push_back(ev_wb(1, 32'h604, 32'h2222_0004));
    exp_q.push_back(ev_wb(0, 32'h500, 32'h1111_0000));
    exp_q.push_back(ev_wb(0, 32'h504, 32'h1111_0004));
    fork
      wb(0, 32'h500, 32'h1111_0000);
      wb(1, 32'h600, 32'h2222_0000);
    join
    drain("rr_second");

    // read-exclusive: C1 holds the dirty line and sees ccinv for the whole transfer
    cctrans[1] = 1'b1; dstore[1] = 32'h0BAD_F00D; inv_hold = 1;
    exp_q.push_back(ev_rd(0, 32'h400, 32'h0BAD_F00D, 1, 1));
    exp_q.push_back(ev_rd(0, 32'h404, 32'h0BAD_F00D, 1, 1));
    rd(0, 32'h400, 1);
    drain("rd_excl");
    inv_hold = 0; cctrans[1] = 1'b0;

    // reset in the middle of a slow fill
    lat = 8;
    dREN[0] = 1'b1; daddr[0] = 32'h700;
    wait_strobe("xfer_start");
    nRST = 1'b0; dREN[0] = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("reset_mid_xfer", sample(), ev_idle());
    @(posedge CLK); #1 nRST = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("post_reset_quiet", sample(), ev_idle());
    end

    // write-back request dropped mid-word
    dWEN[0] = 1'b1; daddr[0] = 32'h800; dstore[0] = 32'h5555_5555;
    wait_strobe("wb_start");
    dWEN[0] = 1'b0;
    @(negedge CLK);
    check("drop_same_cycle", sample(), ev_idle());
    @(negedge CLK);
    check("drop_idle", sample(), ev_idle());
    lat = 2;

    drain("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
